par2ser_stream: RTL and testbench
=================================

# par2ser_stream

Parametrised parallel-to-serial converter with valid/ready handshakes on both sides. It accepts DATA_W-bit words and emits them one bit per transfer, MSB-first or LSB-first. A one-word holding register lets back-to-back words stream without a bubble. It sits between word-oriented datapath logic and single-wire serial links, and tolerates backpressure from the link side.

## Interface
Parameters:
- DATA_W, 4: word width in bits; legal range ≥ 2.
- LSB_FIRST, 0: 0 = bit DATA_W-1 is sent first; 1 = bit 0 is sent first.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word; in_ready = !hold_valid.
- in_data  in  DATA_W  parallel word.
- out_valid  out  1  out_data carries a valid bit.
- out_ready  in  1  link consumes the bit this cycle.
- out_data  out  1  current serial bit.
- out_first  out  1  current bit is the first bit of a word.
- out_last  out  1  current bit is the last bit of a word.

## Operation
- State:
  - sreg[DATA_W-1:0]: shift register.
  - cnt[CNT_W-1:0]: bits sent, with CNT_W = max(1, $clog2(DATA_W)).
  - state ∈ {IDLE, SHIFT}.
  - hreg[DATA_W-1:0] and hold_valid: holding register.
- Handshakes:
  - in_acc = in_valid && in_ready.
  - bit_xfer = out_valid && out_ready.
  - done = bit_xfer && cnt == DATA_W-1.
- Outputs:
  - out_valid = (state == SHIFT).
  - out_data = LSB_FIRST ? sreg[0] : sreg[DATA_W-1].
  - out_first = out_valid && cnt == 0.
  - out_last = out_valid && cnt == DATA_W-1.
- IDLE:
  - in_acc: sreg ← in_data, cnt ← 0, go to SHIFT.
  - hold_valid is always 0 in IDLE.
- SHIFT, bit_xfer && !done:
  - cnt ← cnt+1.
  - sreg shifts by one toward the output end; the vacated bit fills with 0.
- SHIFT, done, selected in priority order:
  - hold_valid: sreg ← hreg, hold_valid ← 0, cnt ← 0, stay in SHIFT.
  - otherwise in_acc: sreg ← in_data, cnt ← 0, stay in SHIFT.
  - otherwise: go to IDLE, cnt ← 0.
- SHIFT, in_acc && !done: hreg ← in_data, hold_valid ← 1.
- in_acc and done in the same cycle with hold_valid = 1 is impossible, because in_ready = 0.
- No bit_xfer (out_ready = 0): sreg, cnt and out_* hold unchanged; a word may still be accepted into hreg.
- Word ordering is strictly FIFO; no word is dropped or duplicated.

## Timing
- Reset values (asynchronous on rst_n low):
  - state = IDLE, sreg = 0, hreg = 0, cnt = 0, hold_valid = 0.
  - Outputs: out_valid = 0, out_data = 0, out_first = 0, out_last = 0, in_ready = 1.
- Latency: word accepted at edge N in IDLE → its first bit is valid after edge N, with out_first = 1.
- Throughput: with out_ready tied 1 and the next word accepted before the last bit, transfer is exactly 1 bit/cycle with no gap. out_last of word k is followed directly by out_first of word k+1.
- cnt wraps to 0 on done for any DATA_W, including non-power-of-two widths; cnt never exceeds DATA_W-1.
- Reset asserted mid-word: the partial word and the held word are discarded. After release, the block restarts from IDLE.
- All outputs are registered-state-derived; there is no combinational path from in_valid or out_ready to any output.

## Structure
- Package par2ser_pkg:
  - state typedef p2s_state_t {IDLE, SHIFT}.
  - function cnt_width(int w) returning max(1, $clog2(w)).
- Single module; no sub-module. The holding register is a few lines and is kept inline.

## Test plan
- Reset: assert rst_n=0 mid-word (DATA_W=4, word 4'b1011, after 2 bits) → out_valid=0 and in_ready=1 immediately. After release, the next word 4'b0110 serialises as 0,1,1,0.
- MSB-first, DATA_W=4, in_data=4'b1011, out_ready=1 → out_data 1,0,1,1 on 4 consecutive cycles. out_first on cycle 1, out_last on cycle 4, then out_valid=0.
- LSB-first, DATA_W=8, in_data=8'hA5 → out_data 1,0,1,0,0,1,0,1.
- Back-to-back, DATA_W=4, words 4'hC, 4'h3 with in_valid held high → 8 contiguous bits 1,1,0,0,0,0,1,1. in_ready drops after the second word is accepted and rises on the cycle after it moves to sreg.
- Backpressure: out_ready=0 for 3 cycles at bit 2 of 4'b1001 → out_data and out_first/out_last stay frozen. A third word offered while hold_valid=1 sees in_ready=0 and is not lost; it is sent after the held word.
- Odd width, DATA_W=5, in_data=5'b10011, MSB-first → 1,0,0,1,1. out_last on cnt=4; cnt returns to 0 and never reaches 5–7.

Source files
------------

// File: rtl/par2ser_pkg.sv
// Shared types and helpers for the parallel-to-serial stream converter.
package par2ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } p2s_state_t;

  // Bit counter width: enough to hold DATA_W-1, never narrower than one bit.
  function automatic int cnt_width(input int w);
    int r;
    r = $clog2(w);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/par2ser_stream.sv
// Parallel-to-serial converter with valid/ready on both sides.
// A one-word holding register lets consecutive words stream without a
// bubble; the link side may stall at any bit.
module par2ser_stream
  import par2ser_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_data,
  output logic              out_first,
  output logic              out_last
);

  localparam int               CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  p2s_state_t        state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [DATA_W-1:0] hreg_q, hreg_d;
  logic              hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              in_acc;
  logic              bit_xfer;
  logic              done;
  logic [DATA_W-1:0] sreg_shifted;

  // Everything visible outside is decoded from registered state only.
  assign out_valid = (state_q == SHIFT);
  assign out_data  = (LSB_FIRST != 0) ? sreg_q[0] : sreg_q[DATA_W-1];
  assign out_first = out_valid && (cnt_q == '0);
  assign out_last  = out_valid && (cnt_q == CNT_LAST);
  assign in_ready  = !hold_q;

  assign in_acc   = in_valid && in_ready;
  assign bit_xfer = out_valid && out_ready;
  assign done     = bit_xfer && (cnt_q == CNT_LAST);

  // Move the next bit to the output end; the vacated position fills with 0.
  assign sreg_shifted = (LSB_FIRST != 0) ? {1'b0, sreg_q[DATA_W-1:1]}
                                         : {sreg_q[DATA_W-2:0], 1'b0};

  // Next-state: load/shift the serialiser and manage the holding register.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    hreg_d  = hreg_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_acc) begin
          sreg_d  = in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (done) begin
          // Held word has priority so ordering stays FIFO; in_ready is low
          // whenever a word is held, so in_acc cannot collide with it here.
          cnt_d = '0;
          if (hold_q) begin
            sreg_d = hreg_q;
            hold_d = 1'b0;
          end else if (in_acc) begin
            sreg_d = in_data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (bit_xfer) begin
            cnt_d  = cnt_q + CNT_W'(1);
            sreg_d = sreg_shifted;
          end
          if (in_acc) begin
            hreg_d = in_data;
            hold_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset discards any partial or held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      hreg_q  <= '0;
      hold_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      hreg_q  <= hreg_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_par2ser_stream.sv
// Bench for par2ser_stream: three instances (4-bit MSB-first, 8-bit
// LSB-first, 5-bit MSB-first) driven from a vector table plus hand-written
// multi-cycle sequences for streaming, backpressure and reset.
module tb_par2ser_stream;

  logic       clk;
  logic       rst_n;
  logic       iv[3];
  logic       ordy[3];
  logic       ov[3];
  logic       od[3];
  logic       ofst[3];
  logic       olst[3];
  logic       ir[3];
  logic [3:0] d4;
  logic [7:0] d8;
  logic [4:0] d5;

  int n_chk;
  int n_fail;

  typedef struct {
    int         sel;
    logic [7:0] din;
    logic [7:0] seq;  // transmission order, first bit in seq[7]
    int         n;
  } vec_t;

  vec_t vecs[7];

  par2ser_stream #(.DATA_W(4), .LSB_FIRST(0)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(d4), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_data(od[0]), .out_first(ofst[0]), .out_last(olst[0])
  );

  par2ser_stream #(.DATA_W(8), .LSB_FIRST(1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(d8), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_data(od[1]), .out_first(ofst[1]), .out_last(olst[1])
  );

  par2ser_stream #(.DATA_W(5), .LSB_FIRST(0)) u5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(d5), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_data(od[2]), .out_first(ofst[2]), .out_last(olst[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_data(input int s, input logic [7:0] v);
    case (s)
      0:       d4 = v[3:0];
      1:       d8 = v;
      default: d5 = v[4:0];
    endcase
  endtask

  // Check one observed serial slot; data is only meaningful while valid.
  task automatic chk_bit(input string tag, input int s, input logic v,
                         input logic d, input logic f, input logic l);
    chk({tag, " valid"}, 32'(ov[s]), 32'(v));
    if (v) chk({tag, " data"}, 32'(od[s]), 32'(d));
    chk({tag, " first"}, 32'(ofst[s]), 32'(f));
    chk({tag, " last"}, 32'(olst[s]), 32'(l));
  endtask

  task automatic run_vec(input int i);
    int s;
    s = vecs[i].sel;
    @(negedge clk);
    set_data(s, vecs[i].din);
    iv[s]   = 1'b1;
    ordy[s] = 1'b1;
    chk($sformatf("vec%0d idle in_ready", i), 32'(ir[s]), 32'd1);
    @(negedge clk);
    iv[s] = 1'b0;
    for (int k = 0; k < vecs[i].n; k++) begin
      chk_bit($sformatf("vec%0d bit%0d", i, k), s, 1'b1, vecs[i].seq[7-k],
              k == 0, k == vecs[i].n - 1);
      @(negedge clk);
    end
    chk_bit($sformatf("vec%0d end", i), s, 1'b0, 1'b0, 1'b0, 1'b0);
    chk($sformatf("vec%0d end in_ready", i), 32'(ir[s]), 32'd1);
  endtask

  // Two words offered back to back with in_valid held high.
  task automatic stream2(input string tag, input int s, input int n,
                         input logic [7:0] w0, input logic [7:0] w1,
                         input logic [15:0] seq);
    @(negedge clk);
    set_data(s, w0);
    iv[s]   = 1'b1;
    ordy[s] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2 * n; k++) begin
      if (k == 0) set_data(s, w1);
      if (k == 1) iv[s] = 1'b0;
      chk_bit($sformatf("%s bit%0d", tag, k), s, 1'b1, seq[15-k],
              (k == 0) || (k == n), (k == n - 1) || (k == 2 * n - 1));
      chk($sformatf("%s bit%0d in_ready", tag, k), 32'(ir[s]),
          32'((k == 0) || (k >= n)));
      @(negedge clk);
    end
    chk_bit({tag, " end"}, s, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [8:0] bp_seq;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    d4 = '0;
    d8 = '0;
    d5 = '0;
    for (int s = 0; s < 3; s++) begin
      iv[s]   = 1'b0;
      ordy[s] = 1'b0;
    end

    vecs[0] = '{sel: 0, din: 8'h0B, seq: 8'b1011_0000, n: 4};
    vecs[1] = '{sel: 0, din: 8'h06, seq: 8'b0110_0000, n: 4};
    vecs[2] = '{sel: 1, din: 8'hA5, seq: 8'b1010_0101, n: 8};
    vecs[3] = '{sel: 1, din: 8'h01, seq: 8'b1000_0000, n: 8};
    vecs[4] = '{sel: 1, din: 8'h0E, seq: 8'b0111_0000, n: 8};
    vecs[5] = '{sel: 2, din: 8'h13, seq: 8'b1001_1000, n: 5};
    vecs[6] = '{sel: 2, din: 8'h08, seq: 8'b0100_0000, n: 5};

    // Reset state of every instance
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst u%0d out_valid", s), 32'(ov[s]), 32'd0);
      chk($sformatf("rst u%0d out_data", s), 32'(od[s]), 32'd0);
      chk($sformatf("rst u%0d out_first", s), 32'(ofst[s]), 32'd0);
      chk($sformatf("rst u%0d out_last", s), 32'(olst[s]), 32'd0);
      chk($sformatf("rst u%0d in_ready", s), 32'(ir[s]), 32'd1);
    end
    rst_n = 1'b1;

    // Reset asserted after two bits of 1011
    @(negedge clk);
    d4 = 4'b1011;
    iv[0]   = 1'b1;
    ordy[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    chk_bit("midrst b0", 0, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk_bit("midrst b1", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_bit("midrst b2", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(ov[0]), 32'd0);
    chk("midrst in_ready", 32'(ir[0]), 32'd1);
    chk("midrst out_data", 32'(od[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: single words on each instance (entry 1 is the post-reset 0110)
    for (int i = 0; i < 7; i++) run_vec(i);

    // Back-to-back streaming, no gap between words
    stream2("b2b4", 0, 4, 8'h0C, 8'h03, 16'b1100_0011_0000_0000);
    stream2("b2b5", 2, 5, 8'h13, 8'h08, 16'b10011_01000_000000);

    // Backpressure: stall 3 cycles at bit 2 of 1001, two more words queued
    @(negedge clk);
    d4 = 4'b1001;
    iv[0]   = 1'b1;
    ordy[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    chk_bit("bp b0", 0, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk_bit("bp b1", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_bit("bp b2", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    ordy[0] = 1'b0;
    d4 = 4'hA;
    iv[0] = 1'b1;
    @(negedge clk);
    chk_bit("bp stall1", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("bp stall1 in_ready", 32'(ir[0]), 32'd0);
    d4 = 4'h5;
    @(negedge clk);
    chk_bit("bp stall2", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("bp stall2 in_ready", 32'(ir[0]), 32'd0);
    @(negedge clk);
    chk_bit("bp stall3", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("bp stall3 in_ready", 32'(ir[0]), 32'd0);
    ordy[0] = 1'b1;
    @(negedge clk);
    bp_seq = 9'b1_1010_0101;
    for (int k = 0; k < 9; k++) begin
      if (k == 2) iv[0] = 1'b0;
      chk_bit($sformatf("bp tail%0d", k), 0, 1'b1, bp_seq[8-k],
              (k == 1) || (k == 5), (k == 0) || (k == 4) || (k == 8));
      chk($sformatf("bp tail%0d in_ready", k), 32'(ir[0]),
          32'((k == 1) || (k >= 5)));
      @(negedge clk);
    end
    chk_bit("bp end", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
